// File: rtl/iob_norm_pkg.sv
// Shared encodings for the sequential leading-bit counter / normaliser.
// Holds the operation modes, FSM states and the count-width derivation.
package iob_norm_pkg;

  localparam logic [1:0] MODE_CLZ = 2'b00;
  localparam logic [1:0] MODE_CLO = 2'b01;
  localparam logic [1:0] MODE_CLS = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_w_f(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/iob_clz_chunk.sv
// Combinational leading-zero counter for one CHUNK_W-bit slice of the scan word.
// An all-zero slice reports CHUNK_W so the caller can add it unconditionally.
module iob_clz_chunk
  import iob_norm_pkg::*;
#(
  parameter int CHUNK_W = 8,
  parameter int LZ_W    = $clog2(CHUNK_W + 1)
) (
  input  logic [CHUNK_W-1:0] i_chunk,
  output logic [LZ_W-1:0]    o_lz,
  output logic               o_all_zero
);

  logic w_found;

  always_comb begin
    o_lz    = LZ_W'(CHUNK_W);
    w_found = 1'b0;
    for (int i = CHUNK_W - 1; i >= 0; i--) begin
      if (!w_found && i_chunk[i]) begin
        o_lz    = LZ_W'(CHUNK_W - 1 - i);
        w_found = 1'b1;
      end
    end
  end

  assign o_all_zero = ~|i_chunk;

endmodule

// File: rtl/iob_norm_seq.sv
// Sequential leading-zero/one/sign counter and normaliser: scans CHUNK_W bits per
// clock, then fine-shifts the data word by the residual count inside the hit chunk.
module iob_norm_seq
  import iob_norm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = cnt_w_f(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [DATA_W-1:0] norm_o,
  output logic              zero_o
);

  localparam int LZ_W = $clog2(CHUNK_W + 1);

  state_t              r_state;
  logic [DATA_W-1:0]   r_scan;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_count;
  logic                r_zero;
  logic                r_is_cls;

  logic [LZ_W-1:0]     w_lz;
  logic                w_all_zero;
  logic                w_last;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_zero_next;

  // CLS scans the bits below the MSB for a change of sign; the forced LSB
  // guarantees a terminating 1 so the count stops at DATA_W-1.
  function automatic logic [DATA_W-1:0] scan_word(input logic [1:0]        mode,
                                                  input logic [DATA_W-1:0] data);
    case (mode)
      MODE_CLO: scan_word = ~data;
      MODE_CLS: scan_word = ((data ^ {DATA_W{data[DATA_W-1]}}) << 1) | DATA_W'(1);
      default:  scan_word = data;
    endcase
  endfunction

  iob_clz_chunk #(
    .CHUNK_W (CHUNK_W),
    .LZ_W    (LZ_W)
  ) u_chunk (
    .i_chunk    (r_scan[DATA_W-1 -: CHUNK_W]),
    .o_lz       (w_lz),
    .o_all_zero (w_all_zero)
  );

  assign w_last      = (r_count == CNT_W'(DATA_W - CHUNK_W));
  assign w_cnt_next  = r_count + CNT_W'(w_lz);
  assign w_zero_next = w_all_zero | (r_is_cls & (w_cnt_next == CNT_W'(DATA_W - 1)));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state  <= ST_IDLE;
      r_scan   <= '0;
      r_data   <= '0;
      r_count  <= '0;
      r_zero   <= 1'b0;
      r_is_cls <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_scan   <= scan_word(mode_i, data_i);
            r_data   <= data_i;
            r_count  <= '0;
            r_zero   <= 1'b0;
            r_is_cls <= (mode_i == MODE_CLS);
            r_state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Coarse step while the chunk is empty; the final step only fine-shifts.
          if (w_all_zero && !w_last) begin
            r_scan  <= r_scan << CHUNK_W;
            r_data  <= r_data << CHUNK_W;
            r_count <= r_count + CNT_W'(CHUNK_W);
          end else begin
            r_count <= w_cnt_next;
            r_data  <= r_data << w_lz;
            r_zero  <= w_zero_next;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (r_state == ST_IDLE);
  assign out_valid_o = (r_state == ST_DONE);
  assign count_o     = r_count;
  assign norm_o      = r_data;
  assign zero_o      = r_zero;

endmodule
